// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 16x2 text LCD sequencer.
// Holds the controller and bus-writer state encodings, HD44780 command bytes,
// and the power-up init command table.
package lcd_pkg;

  typedef enum logic [2:0] {
    S_PWRUP = 3'd0,
    S_INIT  = 3'd1,
    S_IDLE  = 3'd2,
    S_ADDR  = 3'd3,
    S_CHAR  = 3'd4
  } lcd_state_e;

  typedef enum logic [2:0] {
    W_IDLE  = 3'd0,
    W_SETUP = 3'd1,
    W_PULSE = 3'd2,
    W_HOLD  = 3'd3,
    W_WAIT  = 3'd4
  } wr_state_e;

  localparam logic [7:0] LCD_FUNC_8B2L = 8'h38;
  localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
  localparam logic [7:0] LCD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_ENTRY_INC = 8'h06;
  localparam logic [7:0] LCD_ROW0      = 8'h80;
  localparam logic [7:0] LCD_ROW1      = 8'hC0;

  localparam int INIT_LEN = 5;

  // Power-up command sequence: function set is sent twice, then display on, clear, entry mode.
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    init_cmd = LCD_FUNC_8B2L;
      3'd1:    init_cmd = LCD_FUNC_8B2L;
      3'd2:    init_cmd = LCD_DISP_ON;
      3'd3:    init_cmd = LCD_CLEAR;
      3'd4:    init_cmd = LCD_ENTRY_INC;
      default: init_cmd = LCD_FUNC_8B2L;
    endcase
  endfunction

endpackage

// File: rtl/lcd_bus_writer.sv
// Single-byte HD44780 bus transfer engine.
// Ports: i_clk, i_rst (sync, active-high); i_start/i_rs/i_data request one byte;
// o_done pulses for one cycle once the post-transfer wait has elapsed;
// o_en/o_rs/o_data drive the LCD pins (all registered).
// Timeline from the first cycle RS/DATA are driven: EN_CYCLES setup, EN_CYCLES
// high, EN_CYCLES hold, then CMD_WAIT (or CLR_WAIT after a clear command).
module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int EN_CYCLES = 16,
  parameter int CMD_WAIT  = 2000,
  parameter int CLR_WAIT  = 82000,
  parameter int CNT_W     = 18
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  output logic       o_done,
  output logic       o_en,
  output logic       o_rs,
  output logic [7:0] o_data
);

  localparam logic [CNT_W-1:0] EN_LAST = CNT_W'(EN_CYCLES - 1);

  wr_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_clr_q;
  logic             en_q;
  logic             rs_q;
  logic [7:0]       data_q;
  logic             done_q;
  logic [CNT_W-1:0] wait_last_s;

  // The clear command needs a much longer settle time than other bytes.
  assign wait_last_s = is_clr_q ? CNT_W'(CLR_WAIT - 1) : CNT_W'(CMD_WAIT - 1);

  // Transfer sequencer: latches the byte, shapes EN and times the post-wait.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= W_IDLE;
      cnt_q    <= '0;
      is_clr_q <= 1'b0;
      en_q     <= 1'b0;
      rs_q     <= 1'b0;
      data_q   <= 8'h00;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        W_IDLE: begin
          if (i_start) begin
            rs_q     <= i_rs;
            data_q   <= i_data;
            is_clr_q <= !i_rs && (i_data == LCD_CLEAR);
            cnt_q    <= '0;
            state_q  <= W_SETUP;
          end
        end
        W_SETUP: begin
          if (cnt_q == EN_LAST) begin
            cnt_q   <= '0;
            en_q    <= 1'b1;
            state_q <= W_PULSE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        W_PULSE: begin
          if (cnt_q == EN_LAST) begin
            cnt_q   <= '0;
            en_q    <= 1'b0;
            state_q <= W_HOLD;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        W_HOLD: begin
          if (cnt_q == EN_LAST) begin
            cnt_q   <= '0;
            state_q <= W_WAIT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        W_WAIT: begin
          if (cnt_q == wait_last_s) begin
            cnt_q   <= '0;
            done_q  <= 1'b1;
            state_q <= W_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          en_q    <= 1'b0;
          state_q <= W_IDLE;
        end
      endcase
    end
  end

  assign o_done = done_q;
  assign o_en   = en_q;
  assign o_rs   = rs_q;
  assign o_data = data_q;

endmodule

// File: rtl/lcd_text_ctrl.sv
// HD44780 16x2 text LCD controller for the DE2-115 (8-bit bus, write-only).
// Ports: i_clk, i_rst (sync, active-high); i_wr_en/i_wr_addr/i_wr_data write one
// character into the 32-byte text buffer (row0 = 0-15, row1 = 16-31);
// o_ready = init finished; o_busy = refresh pass running or pending;
// io_LCD_DATA/o_LCD_EN/o_LCD_RS drive the panel; RW/ON/BLON are constants.
// After power-up init the full screen is re-sent whenever the buffer was written.
module lcd_text_ctrl
  import lcd_pkg::*;
#(
  parameter int PWRUP_CYCLES = 750000,
  parameter int EN_CYCLES    = 16,
  parameter int CMD_WAIT     = 2000,
  parameter int CLR_WAIT     = 82000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wr_en,
  input  logic [4:0] i_wr_addr,
  input  logic [7:0] i_wr_data,
  output logic       o_ready,
  output logic       o_busy,
  inout  wire  [7:0] io_LCD_DATA,
  output logic       o_LCD_EN,
  output logic       o_LCD_RS,
  output logic       o_LCD_RW,
  output logic       o_LCD_ON,
  output logic       o_LCD_BLON
);

  localparam int MAX_WAIT = (PWRUP_CYCLES > CLR_WAIT) ? PWRUP_CYCLES : CLR_WAIT;
  localparam int CNT_W    = $clog2(MAX_WAIT) + 1;

  lcd_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       init_idx_q;
  logic             row_q;
  logic [3:0]       col_q;
  logic             xfer_q;    // a byte has been handed to the writer and is not yet done
  logic             start_q;
  logic             rs_q;
  logic [7:0]       byte_q;
  logic             dirty_q;
  logic             ready_q;
  logic [7:0]       text_q [32];
  logic             wr_done_s;
  logic [7:0]       lcd_data_s;

  // Text buffer: plain registers, blank (space) after reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 32; i++) text_q[i] <= 8'h20;
    end else if (i_wr_en) begin
      text_q[i_wr_addr] <= i_wr_data;
    end
  end

  // Main sequencer: power-up wait, init commands, then full-screen refresh passes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_PWRUP;
      cnt_q      <= '0;
      init_idx_q <= 3'd0;
      row_q      <= 1'b0;
      col_q      <= 4'd0;
      xfer_q     <= 1'b0;
      start_q    <= 1'b0;
      rs_q       <= 1'b0;
      byte_q     <= 8'h00;
      dirty_q    <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        S_PWRUP: begin
          if (cnt_q == CNT_W'(PWRUP_CYCLES - 1)) begin
            cnt_q   <= '0;
            state_q <= S_INIT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_INIT: begin
          if (!xfer_q) begin
            start_q <= 1'b1;
            rs_q    <= 1'b0;
            byte_q  <= init_cmd(init_idx_q);
            xfer_q  <= 1'b1;
          end else if (wr_done_s) begin
            xfer_q <= 1'b0;
            if (init_idx_q == 3'(INIT_LEN - 1)) begin
              ready_q <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              init_idx_q <= init_idx_q + 3'd1;
            end
          end
        end
        S_IDLE: begin
          if (dirty_q) begin
            dirty_q <= 1'b0;
            row_q   <= 1'b0;
            state_q <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (!xfer_q) begin
            start_q <= 1'b1;
            rs_q    <= 1'b0;
            byte_q  <= row_q ? LCD_ROW1 : LCD_ROW0;
            xfer_q  <= 1'b1;
          end else if (wr_done_s) begin
            xfer_q  <= 1'b0;
            col_q   <= 4'd0;
            state_q <= S_CHAR;
          end
        end
        S_CHAR: begin
          if (!xfer_q) begin
            start_q <= 1'b1;
            rs_q    <= 1'b1;
            byte_q  <= text_q[{row_q, col_q}];
            xfer_q  <= 1'b1;
          end else if (wr_done_s) begin
            xfer_q <= 1'b0;
            if (col_q == 4'd15) begin
              if (!row_q) begin
                row_q   <= 1'b1;
                state_q <= S_ADDR;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              col_q <= col_q + 4'd1;
            end
          end
        end
        default: state_q <= S_PWRUP;
      endcase
      // Placed last so a write in the same cycle as the clear keeps dirty set.
      if (i_wr_en) dirty_q <= 1'b1;
    end
  end

  lcd_bus_writer #(
    .EN_CYCLES (EN_CYCLES),
    .CMD_WAIT  (CMD_WAIT),
    .CLR_WAIT  (CLR_WAIT),
    .CNT_W     (CNT_W)
  ) u_writer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (start_q),
    .i_rs    (rs_q),
    .i_data  (byte_q),
    .o_done  (wr_done_s),
    .o_en    (o_LCD_EN),
    .o_rs    (o_LCD_RS),
    .o_data  (lcd_data_s)
  );

  assign io_LCD_DATA = lcd_data_s;
  assign o_ready     = ready_q;
  assign o_busy      = !((state_q == S_IDLE) && !dirty_q);
  assign o_LCD_RW    = 1'b0;
  assign o_LCD_ON    = 1'b1;
  assign o_LCD_BLON  = 1'b1;

endmodule
